// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM states,
// cycle-type identifiers and a constant-foldable clog2.
package wb_rr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotate-priority encoder: first requester after 'last' (wrapping) wins.
// Output is one-hot plus a valid flag; purely combinational.
module wb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win,
  output logic          valid
);

  // Distance of master j from the slot after 'last'; 0 is highest priority.
  function automatic int rot_dist(input int j, input logic [IW-1:0] l);
    return (j + 2 * N - int'(l) - 1) % N;
  endfunction

  int best;

  always_comb begin
    best = N;
    win  = '0;
    for (int j = 0; j < N; j++)
      if (req[j] && rot_dist(j, last) < best) best = rot_dist(j, last);
    for (int j = 0; j < N; j++)
      if (req[j] && rot_dist(j, last) == best) win[j] = 1'b1;
    valid = (best < N);
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NMASTERS masters share one slave port, grant
// held until the owner drops CYC. Watchdog built only with WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NMASTERS = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [32*NMASTERS-1:0]   m_adr_i,
  input  logic [32*NMASTERS-1:0]   m_dat_i,
  input  logic [4*NMASTERS-1:0]    m_sel_i,
  input  logic [3*NMASTERS-1:0]    m_cti_i,
  input  logic [NMASTERS-1:0]      m_we_i,
  input  logic [NMASTERS-1:0]      m_cyc_i,
  input  logic [NMASTERS-1:0]      m_stb_i,
  output logic [31:0]              m_dat_o,
  output logic [NMASTERS-1:0]      m_ack_o,
  output logic [NMASTERS-1:0]      m_err_o,
  output logic [31:0]              s_adr_o,
  output logic [31:0]              s_dat_o,
  output logic [3:0]               s_sel_o,
  output logic [2:0]               s_cti_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  input  logic [31:0]              s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [NMASTERS-1:0]      grant_o,
  output logic                     timeout_o
);

  localparam int IW = clog2(NMASTERS);

  arb_state_e          state;
  logic [NMASTERS-1:0] grant;
  logic [IW-1:0]       last;
  logic [NMASTERS-1:0] pick_win;
  logic                pick_valid;
  logic [IW-1:0]       pick_idx;
  logic                owner_cyc;
  logic                regrant;
  logic                stb_sel;
  logic                wd_fire;

  wb_rr_pick #(.N(NMASTERS), .IW(IW)) u_pick (
    .req   (m_cyc_i),
    .last  (last),
    .win   (pick_win),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NMASTERS; k++)
      if (pick_win[k]) pick_idx = IW'(k);
  end

  assign owner_cyc = |(grant & m_cyc_i);
  // Re-arbitrate only when nobody holds the bus; bursts and locked sequences ride on CYC.
  assign regrant   = (state == ARB_IDLE) || !owner_cyc;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ARB_IDLE;
      grant <= '0;
      last  <= IW'(NMASTERS - 1);
    end else if (regrant) begin
      if (pick_valid) begin
        state <= ARB_BUSY;
        grant <= pick_win;
        last  <= pick_idx;
      end else begin
        state <= ARB_IDLE;
        grant <= '0;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          grant_chg;

  assign grant_chg = regrant && (pick_win != grant);
  assign wd_fire   = (wd_cnt == CW'(TIMEOUT));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      wd_cnt <= '0;
    else if (wd_fire || s_ack_i || s_err_i || grant_chg)
      wd_cnt <= '0;
    else if (s_cyc_o && s_stb_o)
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  // No watchdog: TIMEOUT has no meaning here and this folds to constant 0.
  assign wd_fire = (TIMEOUT < 0);
`endif

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    stb_sel = 1'b0;
    for (int k = 0; k < NMASTERS; k++) begin
      if (grant[k]) begin
        s_adr_o = m_adr_i[32*k +: 32];
        s_dat_o = m_dat_i[32*k +: 32];
        s_sel_o = m_sel_i[4*k +: 4];
        s_cti_o = m_cti_i[3*k +: 3];
        s_we_o  = m_we_i[k];
        s_cyc_o = m_cyc_i[k];
        stb_sel = m_stb_i[k];
      end
    end
  end

  // A watchdog hit suppresses the strobe so the slave never sees a late start.
  assign s_stb_o   = stb_sel & ~wd_fire;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = grant & m_cyc_i & {NMASTERS{s_ack_i}};
  assign m_err_o   = grant & m_cyc_i & {NMASTERS{s_err_i | wd_fire}};
  assign grant_o   = grant;
  assign timeout_o = wd_fire;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: reset, rotation, burst hold, handover,
// async reset and the watchdog (with or without WB_ARB_TIMEOUT_EN).
module tb_wb_rr_arbiter;

  localparam int N = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic              sys_clk;
  logic              sys_rst_n;
  logic [32*N-1:0]   m_adr_i, m_dat_i;
  logic [4*N-1:0]    m_sel_i;
  logic [3*N-1:0]    m_cti_i;
  logic [N-1:0]      m_we_i, m_cyc_i, m_stb_i;
  logic [31:0]       m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic [2:0]        s_cti_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [31:0]       s_dat_i;
  logic              s_ack_i, s_err_i;
  logic [N-1:0]      grant_o;
  logic              timeout_o;
  logic              ack_en;

  int n_chk  = 0;
  int n_pass = 0;

  wb_rr_arbiter #(.NMASTERS(N), .TIMEOUT(15)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Zero-wait slave; read data tagged by address.
  assign s_ack_i = ack_en & s_cyc_o & s_stb_o;
  assign s_dat_i = s_adr_o ^ KEY;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drv(input int k, input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
    m_cyc_i[k]          = cyc;
    m_stb_i[k]          = cyc;
    m_we_i[k]           = adr[12];
    m_adr_i[32*k +: 32] = adr;
    m_dat_i[32*k +: 32] = ~adr;
    m_sel_i[4*k +: 4]   = adr[15:12];
    m_cti_i[3*k +: 3]   = cti;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] q[$];
    logic [N-1:0] ackd;
    logic [31:0] e;
    logic errd;
    int acks, beat, fires, errs, fire_at;

    sys_rst_n = 1'b0; ack_en = 1'b0; s_err_i = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_cti_i = '0;
    m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;

    // Reset with every master requesting
    for (int k = 0; k < N; k++) drv(k, 1'b1, 32'h1000 * (k + 1), 3'b000);
    tick; tick;
    chk("rst_grant", grant_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_adr", s_adr_o, 0);
    chk("rst_resp", m_ack_o | m_err_o, 0);
    chk("rst_tmo", timeout_o, 0);
    #2 sys_rst_n = 1'b1;
    tick;
    chk("first_grant", grant_o, 4'b0001);
    chk("first_adr", s_adr_o, 32'h1000);
    chk("first_wdat", s_dat_o, ~32'h1000);
    chk("first_sel", s_sel_o, 4'h1);
    chk("first_cyc", s_cyc_o, 1);

    // Rotation: each master drops CYC after one ACK, then re-requests
    ack_en = 1'b1;
    q = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
    acks = 0;
    #1;
    for (int c = 0; c < 40 && acks < 5; c++) begin
      chk("rot_busy", {31'b0, grant_o != 0}, 1);
      ackd = m_ack_o;
      if (ackd != 0) begin
        if (q.size() > 0) chk("rot_ack", ackd, q.pop_front());
        else chk("rot_extra", ackd, 0);
        acks++;
      end
      tick;
      for (int k = 0; k < N; k++) begin
        if (ackd[k]) drv(k, 1'b0, 32'h1000 * (k + 1), 3'b000);
        else if (!m_cyc_i[k]) drv(k, 1'b1, 32'h1000 * (k + 1), 3'b000);
      end
      #1;
    end
    chk("rot_left", q.size(), 0);
    for (int k = 0; k < N; k++) drv(k, 1'b0, 0, 3'b000);
    tick; tick;
    chk("idle_grant", grant_o, 0);

    // Burst hold: master 1 does a 4-beat incrementing burst while master 0 waits
    drv(0, 1'b1, 32'h1000, 3'b000);
    drv(1, 1'b1, 32'h2000, 3'b010);
    q.push_back(32'h2000);
    beat = 0;
    tick;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      chk("burst_own", grant_o, 4'b0010);
      if (m_ack_o[1]) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("burst_adr", s_adr_o, e);
          chk("burst_dat", m_dat_o, e ^ KEY);
          chk("burst_cti", s_cti_o, (beat == 3) ? 3'b111 : 3'b010);
        end else chk("burst_extra", m_ack_o, 0);
        beat++;
      end
      tick;
      if (beat < 4) begin
        drv(1, 1'b1, 32'h2000 + 4 * beat, (beat == 3) ? 3'b111 : 3'b010);
        q.push_back(32'h2000 + 4 * beat);
      end else drv(1, 1'b0, 0, 3'b000);
      #1;
    end
    chk("burst_beats", beat, 4);
    chk("burst_tail", grant_o, 4'b0010);
    chk("burst_tail_cyc", s_cyc_o, 0);
    tick;
    chk("burst_next", grant_o, 4'b0001);
    chk("burst_next_adr", s_adr_o, 32'h1000);
    drv(0, 1'b0, 0, 3'b000);
    tick; tick;

    // Handover with the slave stalled; also ERR pass-through
    ack_en = 1'b0;
    drv(2, 1'b1, 32'h3000, 3'b000);
    tick;
    chk("ho_grant2", grant_o, 4'b0100);
    drv(3, 1'b1, 32'h4000, 3'b000);
    s_err_i = 1'b1;
    #1;
    chk("err_pass", m_err_o, 4'b0100);
    chk("err_noack", m_ack_o, 0);
    s_err_i = 1'b0;
    tick;
    chk("ho_hold", grant_o, 4'b0100);
    chk("ho_adr_old", s_adr_o, 32'h3000);
    drv(2, 1'b0, 0, 3'b000);
    tick;
    chk("ho_grant3", grant_o, 4'b1000);
    chk("ho_adr_new", s_adr_o, 32'h4000);
    drv(3, 1'b0, 0, 3'b000);
    tick; tick;

    // Async reset mid-burst, between edges
    ack_en = 1'b1;
    drv(1, 1'b1, 32'h5000, 3'b010);
    tick;
    chk("arst_pre", s_cyc_o, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_cyc", s_cyc_o, 0);
    chk("arst_grant", grant_o, 0);
    chk("arst_ack", m_ack_o, 0);
    drv(1, 1'b0, 0, 3'b000);
    #2 sys_rst_n = 1'b1;
    tick;

    // Masters 0 and 2 request while master 1 owns: master 2 is next
    ack_en = 1'b0;
    drv(1, 1'b1, 32'h6000, 3'b000);
    tick;
    chk("prio_m1", grant_o, 4'b0010);
    drv(0, 1'b1, 32'h1000, 3'b000);
    drv(2, 1'b1, 32'h3000, 3'b000);
    tick;
    drv(1, 1'b0, 0, 3'b000);
    tick;
    chk("prio_m2", grant_o, 4'b0100);
    for (int k = 0; k < N; k++) drv(k, 1'b0, 0, 3'b000);
    tick; tick;

    // Stalled slave: watchdog fires once, or never when not built
    drv(0, 1'b1, 32'h7000, 3'b000);
`ifdef WB_ARB_TIMEOUT_EN
    q.push_back(32'd15);
`endif
    tick;
    chk("wd_grant", grant_o, 4'b0001);
    fires = 0; errs = 0; fire_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (m_err_o != 0) errs++;
      if (timeout_o) begin
        fires++;
        if (q.size() > 0) chk("wd_at", c, q.pop_front());
        else chk("wd_extra", c, 0);
        chk("wd_err", m_err_o, 4'b0001);
        chk("wd_stb", s_stb_o, 0);
      end
      errd = m_err_o[0];
      tick;
      if (errd) drv(0, 1'b0, 0, 3'b000);
      #1;
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("wd_fires", fires, 1);
    chk("wd_left", q.size(), 0);
`else
    chk("wd_fires", fires, 0);
    chk("wd_errs", errs, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
